// File: rtl/bank_mem_pkg.sv
// Shared definitions for the 4-bank Hamming-coded memory: bank geometry,
// requester ids and the check-bit derivation used to size coded words.
package bank_mem_pkg;

  localparam int BANK_W    = 2;
  localparam int NUM_BANKS = 4;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  function automatic int parity_bits(input int data_width);
    return $clog2(data_width) + 1;
  endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// Fixed-depth shift register carrying {valid, requester id} alongside each
// issued read so the returning word can be steered to its requester.
module rd_tag_pipe
  import bank_mem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    clr,
  input  logic    push_valid,
  input  req_id_e push_id,
  output logic    pop_valid,
  output req_id_e pop_id
);

  logic    valid_q [DEPTH];
  req_id_e id_q    [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        id_q[i]    <= REQ_A;
      end
    end else begin
      valid_q[0] <= push_valid;
      id_q[0]    <= push_id;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        id_q[i]    <= id_q[i-1];
      end
    end
  end

  assign pop_valid = valid_q[DEPTH-1];
  assign pop_id    = id_q[DEPTH-1];

endmodule

// File: rtl/bank_access_scheduler.sv
// Two-requester round-robin scheduler for the 4-bank coded memory with a
// per-bank recovery window, a registered issue port and tagged read return.
module bank_access_scheduler
  import bank_mem_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int PARITY_BITS   = parity_bits(DATA_WIDTH),
  parameter int CODE_WIDTH    = DATA_WIDTH + PARITY_BITS + 1,
  parameter int ADDR_WIDTH    = 6,
  parameter int RD_LATENCY    = 2,
  parameter int BANK_RECOVERY = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_req_a,
  input  logic                         i_we_a,
  input  logic [ADDR_WIDTH-1:0]        i_addr_a,
  input  logic [CODE_WIDTH-1:0]        i_wdata_a,
  output logic                         o_gnt_a,
  output logic                         o_rvalid_a,
  input  logic                         i_req_b,
  input  logic                         i_we_b,
  input  logic [ADDR_WIDTH-1:0]        i_addr_b,
  input  logic [CODE_WIDTH-1:0]        i_wdata_b,
  output logic                         o_gnt_b,
  output logic                         o_rvalid_b,
  output logic [CODE_WIDTH-1:0]        o_rdata,
  output logic                         o_mem_en,
  output logic                         o_mem_we,
  output logic [BANK_W-1:0]            o_mem_sel,
  output logic [ADDR_WIDTH-BANK_W-1:0] o_mem_addr,
  output logic [CODE_WIDTH-1:0]        o_mem_wdata,
  input  logic [CODE_WIDTH-1:0]        i_mem_rdata
);

  localparam int IN_BANK_W = ADDR_WIDTH - BANK_W;
  localparam int CNT_W     = (BANK_RECOVERY > 0) ? $clog2(BANK_RECOVERY + 1) : 1;

  // Handshake: a requester raises req with we/addr/wdata stable and keeps them
  // until it sees its one-cycle gnt; the request is consumed at the end of that
  // gnt cycle, so a still-high req during gnt is masked from arbitration.
  logic [BANK_W-1:0] bank_a, bank_b;
  logic [CNT_W-1:0]  cnt [NUM_BANKS];
  req_id_e           ptr;
  logic              elig_a, elig_b, pick_a, pick_b;
  logic              push_valid, pop_valid;
  req_id_e           push_id, pop_id;

  assign bank_a = i_addr_a[ADDR_WIDTH-1 -: BANK_W];
  assign bank_b = i_addr_b[ADDR_WIDTH-1 -: BANK_W];

  always_comb begin
    elig_a = i_req_a && !o_gnt_a && (cnt[bank_a] == '0);
    elig_b = i_req_b && !o_gnt_b && (cnt[bank_b] == '0);
    pick_a = 1'b0;
    pick_b = 1'b0;
    if (elig_a && elig_b) begin
      pick_a = (ptr == REQ_A);
      pick_b = (ptr == REQ_B);
    end else begin
      pick_a = elig_a;
      pick_b = elig_b;
    end
  end

  // The read tag enters the pipe on the same edge that raises o_mem_en, so it
  // exits after RD_LATENCY edges, when o_rdata captures i_mem_rdata.
  assign push_valid = (o_gnt_a && !i_we_a) || (o_gnt_b && !i_we_b);
  assign push_id    = o_gnt_b ? REQ_B : REQ_A;

  rd_tag_pipe #(
    .DEPTH (RD_LATENCY)
  ) u_rd_tag_pipe (
    .clk        (i_clk),
    .clr        (i_rst),
    .push_valid (push_valid),
    .push_id    (push_id),
    .pop_valid  (pop_valid),
    .pop_id     (pop_id)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_gnt_a     <= 1'b0;
      o_gnt_b     <= 1'b0;
      ptr         <= REQ_A;
      for (int k = 0; k < NUM_BANKS; k++) cnt[k] <= '0;
      o_mem_en    <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_sel   <= '0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_rvalid_a  <= 1'b0;
      o_rvalid_b  <= 1'b0;
      o_rdata     <= '0;
    end else begin
      o_gnt_a <= pick_a;
      o_gnt_b <= pick_b;
      if (pick_a || pick_b) ptr <= pick_a ? REQ_B : REQ_A;

      for (int k = 0; k < NUM_BANKS; k++) begin
        if ((pick_a && bank_a == BANK_W'(k)) || (pick_b && bank_b == BANK_W'(k)))
          cnt[k] <= CNT_W'(BANK_RECOVERY);
        else if (cnt[k] != '0)
          cnt[k] <= cnt[k] - CNT_W'(1);
      end

      // Fields are still held by the requester during its gnt cycle.
      o_mem_en <= o_gnt_a || o_gnt_b;
      if (o_gnt_a) begin
        o_mem_we    <= i_we_a;
        o_mem_sel   <= bank_a;
        o_mem_addr  <= i_addr_a[IN_BANK_W-1:0];
        o_mem_wdata <= i_wdata_a;
      end else if (o_gnt_b) begin
        o_mem_we    <= i_we_b;
        o_mem_sel   <= bank_b;
        o_mem_addr  <= i_addr_b[IN_BANK_W-1:0];
        o_mem_wdata <= i_wdata_b;
      end

      o_rvalid_a <= pop_valid && (pop_id == REQ_A);
      o_rvalid_b <= pop_valid && (pop_id == REQ_B);
      if (pop_valid) o_rdata <= i_mem_rdata;
    end
  end

endmodule

// File: tb/tb_bank_access_scheduler.sv
// Directed bench for bank_access_scheduler: drivers issue requests, expected
// grants/issues/read returns go into queues that a negedge monitor drains.
module tb_bank_access_scheduler;

  localparam int CW = 13;

  logic          clk;
  logic          i_rst;
  logic          i_req_a, i_we_a, i_req_b, i_we_b;
  logic [5:0]    i_addr_a, i_addr_b;
  logic [CW-1:0] i_wdata_a, i_wdata_b;
  logic          o_gnt_a, o_gnt_b, o_rvalid_a, o_rvalid_b;
  logic [CW-1:0] o_rdata;
  logic          o_mem_en, o_mem_we;
  logic [1:0]    o_mem_sel;
  logic [3:0]    o_mem_addr;
  logic [CW-1:0] o_mem_wdata;
  logic [CW-1:0] i_mem_rdata;

  bank_access_scheduler dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_req_a     (i_req_a),
    .i_we_a      (i_we_a),
    .i_addr_a    (i_addr_a),
    .i_wdata_a   (i_wdata_a),
    .o_gnt_a     (o_gnt_a),
    .o_rvalid_a  (o_rvalid_a),
    .i_req_b     (i_req_b),
    .i_we_b      (i_we_b),
    .i_addr_b    (i_addr_b),
    .i_wdata_b   (i_wdata_b),
    .o_gnt_b     (o_gnt_b),
    .o_rvalid_b  (o_rvalid_b),
    .o_rdata     (o_rdata),
    .o_mem_en    (o_mem_en),
    .o_mem_we    (o_mem_we),
    .o_mem_sel   (o_mem_sel),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_rdata (i_mem_rdata)
  );

  // ---------------- clock / cycle counter ----------------
  int cyc = 0;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bank memory model (2-cycle read) ----------------
  logic [CW-1:0] mem [64];
  bit   [CW-1:0] mem_rd;
  bit            mem_loaded;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 64; i++) mem[i] <= 13'h1C00 | 13'(i);
      mem_loaded <= 1'b1;
    end else if (o_mem_en) begin
      if (o_mem_we) mem[{o_mem_sel, o_mem_addr}] <= o_mem_wdata;
      else          mem_rd <= mem[{o_mem_sel, o_mem_addr}];
    end
  end
  assign i_mem_rdata = mem_rd;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [33:0] gnt_exp_q [$];  // {cycle, gnt_a, gnt_b}
  logic [51:0] iss_exp_q [$];  // {cycle, we, sel, addr, wdata}
  logic [46:0] rd_exp_q  [$];  // {cycle, rvalid_a, rvalid_b, rdata}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %h expected nothing (cycle %0d)", name, act, cyc);
  endtask

  task automatic exp_gnt(input int c, input logic [1:0] ab);
    gnt_exp_q.push_back({32'(c), ab});
  endtask

  task automatic exp_iss(input int c, input logic we, input logic [1:0] sel,
                         input logic [3:0] addr, input logic [CW-1:0] wd);
    iss_exp_q.push_back({32'(c), we, sel, addr, wd});
  endtask

  task automatic exp_rd(input int c, input logic [1:0] ab, input logic [CW-1:0] d);
    rd_exp_q.push_back({32'(c), ab, d});
  endtask

  always @(negedge clk) begin
    logic [33:0] ga;
    logic [51:0] ia;
    logic [46:0] ra;
    ga = {32'(cyc), o_gnt_a, o_gnt_b};
    ia = {32'(cyc), o_mem_we, o_mem_sel, o_mem_addr, o_mem_wdata};
    ra = {32'(cyc), o_rvalid_a, o_rvalid_b, o_rdata};
    if (o_gnt_a || o_gnt_b) begin
      if (gnt_exp_q.size() == 0) unexpected("grant", 64'(ga));
      else check("grant", 64'(ga), 64'(gnt_exp_q.pop_front()));
    end
    if (o_mem_en) begin
      if (iss_exp_q.size() == 0) unexpected("issue", 64'(ia));
      else check("issue", 64'(ia), 64'(iss_exp_q.pop_front()));
    end
    if (o_rvalid_a || o_rvalid_b) begin
      if (rd_exp_q.size() == 0) unexpected("rdata", 64'(ra));
      else check("rdata", 64'(ra), 64'(rd_exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_a(input logic we, input logic [5:0] addr, input logic [CW-1:0] wd);
    bit got = 1'b0;
    i_req_a = 1'b1; i_we_a = we; i_addr_a = addr; i_wdata_a = wd;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (o_gnt_a) got = 1'b1;
    end
    if (!got) unexpected("gnt_a_timeout", 64'(addr));
    @(posedge clk);
    #1 i_req_a = 1'b0;
  endtask

  task automatic drive_b(input logic we, input logic [5:0] addr, input logic [CW-1:0] wd);
    bit got = 1'b0;
    i_req_b = 1'b1; i_we_b = we; i_addr_b = addr; i_wdata_b = wd;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (o_gnt_b) got = 1'b1;
    end
    if (!got) unexpected("gnt_b_timeout", 64'(addr));
    @(posedge clk);
    #1 i_req_b = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, 64'({o_gnt_a, o_gnt_b, o_rvalid_a, o_rvalid_b, o_rdata, o_mem_en,
                     o_mem_we, o_mem_sel, o_mem_addr, o_mem_wdata}), 64'h0);
  endtask

  task automatic start_test(output int base);
    repeat (10) @(posedge clk);
    @(posedge clk);
    #1 base = cyc;
  endtask

  // ---------------- stimulus ----------------
  int base;
  initial begin
    i_rst = 1'b1;
    i_req_a = 1'b0; i_we_a = 1'b0; i_addr_a = '0; i_wdata_a = '0;
    i_req_b = 1'b0; i_we_b = 1'b0; i_addr_b = '0; i_wdata_b = '0;
    @(posedge clk);
    #1;

    // Reset with both requests held, then different banks back to back.
    fork
      drive_a(1'b0, 6'h05, 13'h0);
      drive_b(1'b1, 6'h25, 13'h0AA);
      begin
        repeat (3) begin
          @(negedge clk);
          check_reset_outputs("reset_outputs");
          @(posedge clk);
        end
        #1 i_rst = 1'b0;
        base = cyc;
        exp_gnt(base + 1, 2'b10);
        exp_gnt(base + 2, 2'b01);
        exp_iss(base + 2, 1'b0, 2'd0, 4'h5, 13'h0);
        exp_iss(base + 3, 1'b1, 2'd2, 4'h5, 13'h0AA);
        exp_rd(base + 4, 2'b10, 13'h1C05);
      end
    join

    // Same bank: second access waits out the recovery window.
    start_test(base);
    exp_gnt(base + 1, 2'b10);
    exp_gnt(base + 4, 2'b01);
    exp_iss(base + 2, 1'b0, 2'd1, 4'h0, 13'h0);
    exp_iss(base + 5, 1'b0, 2'd1, 4'hA, 13'h0);
    exp_rd(base + 4, 2'b10, 13'h1C10);
    exp_rd(base + 7, 2'b01, 13'h1C1A);
    fork
      drive_a(1'b0, 6'h10, 13'h0);
      drive_b(1'b0, 6'h1A, 13'h0);
    join

    // Skip: B holds priority but its bank recovers, so A goes first.
    start_test(base);
    exp_gnt(base + 1, 2'b10);
    exp_gnt(base + 3, 2'b10);
    exp_gnt(base + 4, 2'b01);
    exp_iss(base + 2, 1'b1, 2'd3, 4'h0, 13'h0F0);
    exp_iss(base + 4, 1'b0, 2'd0, 4'h2, 13'h0);
    exp_iss(base + 5, 1'b0, 2'd3, 4'h0, 13'h0);
    exp_rd(base + 6, 2'b10, 13'h1C02);
    exp_rd(base + 7, 2'b01, 13'h0F0);
    fork
      begin
        drive_a(1'b1, 6'h30, 13'h0F0);
        drive_a(1'b0, 6'h02, 13'h0);
      end
      begin
        @(posedge clk);
        #1 drive_b(1'b0, 6'h30, 13'h0);
      end
    join

    // Readback: A writes 6'h3F, B reads it back.
    start_test(base);
    exp_gnt(base + 1, 2'b10);
    exp_gnt(base + 4, 2'b01);
    exp_iss(base + 2, 1'b1, 2'd3, 4'hF, 13'h1A5);
    exp_iss(base + 5, 1'b0, 2'd3, 4'hF, 13'h0);
    exp_rd(base + 7, 2'b01, 13'h1A5);
    fork
      drive_a(1'b1, 6'h3F, 13'h1A5);
      drive_b(1'b0, 6'h3F, 13'h0);
    join

    // Reset one cycle after a read issues: no return, pointer back to A.
    start_test(base);
    exp_gnt(base + 1, 2'b10);
    exp_iss(base + 2, 1'b0, 2'd0, 4'h5, 13'h0);
    drive_a(1'b0, 6'h05, 13'h0);
    @(posedge clk);
    #1 i_rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midread_reset_outputs");
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midread_reset_outputs");
    @(posedge clk);
    #1 i_rst = 1'b0;
    base = cyc;
    exp_gnt(base + 1, 2'b10);
    exp_gnt(base + 2, 2'b01);
    exp_iss(base + 2, 1'b0, 2'd1, 4'h1, 13'h0);
    exp_iss(base + 3, 1'b0, 2'd2, 4'h1, 13'h0);
    exp_rd(base + 4, 2'b10, 13'h1C11);
    exp_rd(base + 5, 2'b01, 13'h1C21);
    fork
      drive_a(1'b0, 6'h11, 13'h0);
      drive_b(1'b0, 6'h21, 13'h0);
    join

    repeat (12) @(posedge clk);
    @(negedge clk);
    check("gnt_queue_drained", 64'(gnt_exp_q.size()), 64'h0);
    check("iss_queue_drained", 64'(iss_exp_q.size()), 64'h0);
    check("rd_queue_drained", 64'(rd_exp_q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
